// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU units: operation modes, NZCV flag positions, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        MODE_SUB = 2'b00,
        MODE_SBC = 2'b01,
        MODE_RSB = 2'b10,
        MODE_CMP = 2'b11
    } alu_mode_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } sub_state_e;

endpackage

// File: rtl/digit_sub_slice.sv
// One digit of x - y as a ripple add of x, ~y and the incoming carry (1 = no borrow).
// Latency: combinational.
// Backpressure: none.
module digit_sub_slice #(
    parameter int D = 8
) (
    input  logic [D-1:0] x,
    input  logic [D-1:0] y,
    input  logic         cin,
    output logic [D-1:0] d,
    output logic         cout
);

    logic [D-1:0] y_n;
    logic [D:0]   c;

    assign y_n  = ~y;
    assign c[0] = cin;

    for (genvar i = 0; i < D; i++) begin : g_bit
        assign d[i]   = x[i] ^ y_n[i] ^ c[i];
        assign c[i+1] = (x[i] & y_n[i]) | (c[i] & (x[i] ^ y_n[i]));
    end

    assign cout = c[D];

endmodule

// File: rtl/multicycle_subtractor.sv
// Digit-serial N-bit subtract/compare with NZCV flags, D bits per cycle, LSB digit first.
// Latency: N/D + 1 cycles from accepted start to done; one op per N/D + 1 cycles.
// Backpressure: start is ignored while busy; no queueing.
module multicycle_subtractor
    import alu_seq_pkg::*;
#(
    parameter int N = 32,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    localparam int K  = N / D;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    if (D < 1 || (N % D) != 0) begin : g_bad_params
        $error("multicycle_subtractor: N must be a positive multiple of D");
    end

    sub_state_e   state, nxt;
    logic [N-1:0] opx, opy, r_sh, r_next, d_ext;
    logic [CW-1:0] cnt;
    logic         carry, msb_x, msb_y, cmp_q;
    logic [D-1:0] dig;
    logic         dig_cout, last, accept;

    digit_sub_slice #(.D(D)) u_slice (
        .x    (opx[D-1:0]),
        .y    (opy[D-1:0]),
        .cin  (carry),
        .d    (dig),
        .cout (dig_cout)
    );

    assign last   = (cnt == CW'(K - 1));
    assign accept = start && (state != ST_RUN);
    assign busy   = (state == ST_RUN);
    assign done   = (state == ST_DONE);

    // New digits enter at the MSB so the LSB digit lands at bit 0 after K shifts.
    always_comb begin
        d_ext            = '0;
        d_ext[N-1 -: D]  = dig;
        r_next           = d_ext | (r_sh >> D);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (start) nxt = ST_RUN;
            ST_RUN:  if (last)  nxt = ST_DONE;
            ST_DONE: nxt = start ? ST_RUN : ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opx    <= '0;
            opy    <= '0;
            r_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            msb_x  <= 1'b0;
            msb_y  <= 1'b0;
            cmp_q  <= 1'b0;
            result <= '0;
            flags  <= 4'b0000;
        end else if (accept) begin
            opx   <= (mode == MODE_RSB) ? b : a;
            opy   <= (mode == MODE_RSB) ? a : b;
            msb_x <= (mode == MODE_RSB) ? b[N-1] : a[N-1];
            msb_y <= (mode == MODE_RSB) ? a[N-1] : b[N-1];
            carry <= (mode == MODE_SBC) ? carry_in : 1'b1;
            cmp_q <= (mode == MODE_CMP);
            r_sh  <= '0;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            opx   <= opx >> D;
            opy   <= opy >> D;
            carry <= dig_cout;
            r_sh  <= r_next;
            cnt   <= cnt + 1'b1;
            if (last) begin
                flags[FLAG_N] <= r_next[N-1];
                flags[FLAG_Z] <= (r_next == '0);
                flags[FLAG_C] <= dig_cout;
                flags[FLAG_V] <= (msb_x ^ msb_y) & (msb_x ^ r_next[N-1]);
                if (!cmp_q) result <= r_next;
            end
        end
    end

endmodule

// File: doc/multicycle_subtractor.md
# multicycle_subtractor

Parametrised digit-serial subtract/compare unit for the ALU datapath. It processes an N-bit subtraction D bits per clock, LSB digit first, under a start/busy/done handshake. It produces full architectural NZCV flags: signed negative, true no-borrow carry, and overflow. It adds subtract-with-borrow, reverse-subtract and flags-only compare modes.

## Interface
- N, default 32: operand and result width; N must be a multiple of D.
- D, default 8: digit width processed per cycle; K = N/D cycles per operation.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- mode  in  2  00 SUB (a-b), 01 SBC (a-b-!carry_in), 10 RSB (b-a), 11 CMP (a-b, flags only).
- a  in  N  minuend for SUB/SBC/CMP, subtrahend for RSB.
- b  in  N  subtrahend for SUB/SBC/CMP, minuend for RSB.
- carry_in  in  1  carry flag input for SBC; 1 = no pending borrow.
- busy  out  1  operation in progress.
- done  out  1  single-cycle completion pulse.
- result  out  N  registered difference; held until the next non-CMP completion.
- flags  out  4  [3] N, [2] Z, [1] C, [0] V; registered and held until the next completion.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1: latch the operands, mode and the initial carry, then go to RUN.
  - Operand order: opx=a, opy=b; RSB swaps them (opx=b, opy=a).
  - Initial carry: carry_in for SBC, 1 for all other modes.
- RUN: each cycle computes digit = opx[D-1:0] + ~opy[D-1:0] + carry.
  - The digit shifts into the result shift register at the MSB end.
  - opx and opy shift right by D.
  - The digit carry-out becomes the next carry.
  - A digit counter runs 0..K-1; after digit K-1, go to DONE.
- DONE: lasts one cycle with done=1, then IDLE, unless start=1, which goes straight to RUN.
- Flag rules, computed from the final state:
  - N = r[N-1].
  - Z = (r == 0).
  - C = final carry-out (1 = no borrow, i.e. opx >= opy unsigned; SBC includes borrow-in).
  - V = (opx[N-1] ^ opy[N-1]) & (opx[N-1] ^ r[N-1]), using the original MSBs saved at start.
- CMP updates flags only; result keeps its previous value.
- Arithmetic is modulo 2^N; no width extension on the result.
- start while busy=1 is ignored; no queueing.
- mode, a, b and carry_in are don't-care outside the start-sampling cycle.

## Timing
- Start is sampled at edge 0.
- busy=1 during cycles 1..K.
- At edge K+1, result/flags update and done=1 for exactly cycle K+1, with busy=0.
- Latency from the start edge to valid done/result is K+1 edges.
- Back-to-back: start=1 during the done cycle is accepted; throughput is one operation per K+1 cycles.
- Reset (any state, including mid-RUN):
  - State goes to IDLE.
  - busy=0, done=0, result=0, flags=4'b0000, counter=0.
  - An abandoned operation never produces done.
- rst has priority over start in the same cycle.
- K=1 (D=N) is legal: busy for one cycle, done on the next.

## Structure
- Shared package alu_seq_pkg holds:
  - the mode enum (SUB, SBC, RSB, CMP);
  - flag index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0);
  - the FSM state enum.
- One sub-module: digit_sub_slice #(D), combinational.
  - Inputs: x[D-1:0], y[D-1:0], cin.
  - Outputs: d[D-1:0], cout.
  - Built on the existing ripple adder with inverted y.
- Everything else (shift registers, counter, FSM, flag logic) lives in multicycle_subtractor.
- Elaboration check: error if N % D != 0 or D < 1.

## Test plan
(N=8, D=4, K=2)
- SUB a=0x05 b=0x03 -> done in cycle 3; result=0x02, flags N0 Z0 C1 V0; busy high in cycles 1-2 only.
- SUB a=0x03 b=0x05 -> result=0xFE, flags N1 Z0 C0 V0.
- SUB a=0x80 b=0x01 -> result=0x7F, flags N0 Z0 C1 V1.
- CMP a=0x2A b=0x2A, issued back-to-back in the done cycle of the previous op:
  - result stays 0x7F;
  - flags N0 Z1 C1 V0;
  - done in the expected cycle with no idle gap.
- SBC a=0x10 b=0x01 carry_in=0 -> result 0x0E, C1.
- RSB a=0x01 b=0x10 -> result 0x0F, C1.
- Start, then rst=1 in cycle 1 -> next cycle busy=0, done=0, result=0x00, flags=0; no later done pulse.
- A start pulse in cycle 2 of a later op is ignored: exactly one done.
